// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receive path:
// FSM state encoding, parity-mode codes and the shortest legal data length.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Data lengths below this value are treated as a configuration error.
  localparam int MIN_DATA_BITS = 5;

  // Mode 2'b11 is an alias for "no parity".
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running baud tick generator: counts 0..i_tick_cmp-1 and emits a
// one-cycle tick at the terminal count. A divisor of 0 or 1 ticks every cycle.
module uart_baud_tick #(
  parameter int NB_COUNTER = 32
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic [NB_COUNTER-1:0] i_tick_cmp,
  output logic                  o_tick
);

  logic [NB_COUNTER-1:0] cnt_q;
  logic [NB_COUNTER-1:0] cnt_d;
  logic                  terminal;

  // Terminal-count detect; ">=" keeps the counter sane if the divisor is
  // lowered below the current count at runtime.
  always_comb begin
    terminal = 1'b0;
    cnt_d    = cnt_q;
    if (i_tick_cmp <= NB_COUNTER'(1)) begin
      terminal = 1'b1;
    end else if (cnt_q >= (i_tick_cmp - NB_COUNTER'(1))) begin
      terminal = 1'b1;
    end
    if (terminal) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + NB_COUNTER'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = terminal;

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: input synchronizer, 5..NB_DATA data
// bits, none/even/odd parity, one or two stop bits, with parity, framing
// and break reporting. Frame settings are captured at the start edge.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int NB_COUNTER = 32,
  parameter int NB_SYNC    = 2,
  parameter int OVERSAMPLE = 16,
  parameter int NB_DBITS   = $clog2(NB_DATA + 1)
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx,
  input  logic                  i_en,
  input  logic [NB_COUNTER-1:0] i_tick_cmp,
  input  logic [NB_DBITS-1:0]   i_data_bits,
  input  logic [1:0]            i_parity_mode,
  input  logic                  i_two_stop,
  output logic [NB_DATA-1:0]    o_rdata,
  output logic                  o_rx_done,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break,
  output logic                  o_busy
);

  localparam int NB_SCNT = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [NB_SCNT-1:0] S_MID  = NB_SCNT'(OVERSAMPLE / 2 - 1);
  localparam logic [NB_SCNT-1:0] S_LAST = NB_SCNT'(OVERSAMPLE - 1);

  // ---------------------------------------------------------------------
  // Input synchronizer, preset to the idle (high) line level.
  // ---------------------------------------------------------------------
  logic [NB_SYNC-1:0] sync_q;
  logic               rx_s;

  // Shift the raw pin through NB_SYNC flops.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[NB_SYNC-2:0], i_rx};
    end
  end

  assign rx_s = sync_q[NB_SYNC-1];

  // ---------------------------------------------------------------------
  // Baud tick
  // ---------------------------------------------------------------------
  logic tick;

  uart_baud_tick #(
    .NB_COUNTER (NB_COUNTER)
  ) u_baud_tick (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_tick_cmp (i_tick_cmp),
    .o_tick     (tick)
  );

  // ---------------------------------------------------------------------
  // Receive state
  // ---------------------------------------------------------------------
  rx_state_e            state_q,      state_d;
  logic [NB_SCNT-1:0]   s_cnt_q,      s_cnt_d;
  logic [NB_DBITS-1:0]  n_cnt_q,      n_cnt_d;
  logic [NB_DATA-1:0]   shift_q,      shift_d;
  logic [NB_DBITS-1:0]  len_q,        len_d;
  logic [1:0]           par_mode_q,   par_mode_d;
  logic                 two_stop_q,   two_stop_d;
  logic                 stop_idx_q,   stop_idx_d;
  logic                 par_bit_q,    par_bit_d;
  logic                 ferr_acc_q,   ferr_acc_d;
  logic                 stop1_bad_q,  stop1_bad_d;
  logic                 armed_q,      armed_d;
  logic                 done_q,       done_d;
  logic [NB_DATA-1:0]   rdata_q,      rdata_d;
  logic                 perr_q,       perr_d;
  logic                 ferr_q,       ferr_d;
  logic                 brk_q,        brk_d;

  // Clamped data length as it would be latched at a start edge.
  logic [NB_DBITS-1:0]  len_cfg;
  // Stop-bit evaluation helpers for the current sample.
  logic                 ferr_now;
  logic                 stop1_bad_now;
  logic                 data_par;

  // Out-of-range lengths fall back to the full word width.
  always_comb begin
    len_cfg = i_data_bits;
    if ((i_data_bits < NB_DBITS'(MIN_DATA_BITS)) ||
        (i_data_bits > NB_DBITS'(NB_DATA))) begin
      len_cfg = NB_DBITS'(NB_DATA);
    end
  end

  // Next-state and datapath logic for the receive FSM.
  always_comb begin
    state_d       = state_q;
    s_cnt_d       = s_cnt_q;
    n_cnt_d       = n_cnt_q;
    shift_d       = shift_q;
    len_d         = len_q;
    par_mode_d    = par_mode_q;
    two_stop_d    = two_stop_q;
    stop_idx_d    = stop_idx_q;
    par_bit_d     = par_bit_q;
    ferr_acc_d    = ferr_acc_q;
    stop1_bad_d   = stop1_bad_q;
    armed_d       = armed_q;
    done_d        = 1'b0;
    rdata_d       = rdata_q;
    perr_d        = perr_q;
    ferr_d        = ferr_q;
    brk_d         = brk_q;
    ferr_now      = ferr_acc_q | ~rx_s;
    stop1_bad_now = stop_idx_q ? stop1_bad_q : ~rx_s;
    // Unused MSBs of the shift register stay 0, so a full reduction works
    // for every configured length.
    data_par      = ^shift_q;

    unique case (state_q)
      ST_IDLE: begin
        // A high line after a bad frame allows the next start edge.
        if (rx_s) begin
          armed_d = 1'b1;
        end
        if (armed_q && i_en && !rx_s) begin
          state_d     = ST_START;
          s_cnt_d     = '0;
          len_d       = len_cfg;
          par_mode_d  = i_parity_mode;
          two_stop_d  = i_two_stop;
          shift_d     = '0;
          stop_idx_d  = 1'b0;
          par_bit_d   = 1'b0;
          ferr_acc_d  = 1'b0;
          stop1_bad_d = 1'b0;
        end
      end

      ST_START: begin
        if (tick) begin
          if (s_cnt_q == S_MID) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
            // A start bit that is high again at mid-bit was only a glitch.
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            s_cnt_d = s_cnt_q + NB_SCNT'(1);
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            for (int i = 0; i < NB_DATA; i++) begin
              if (n_cnt_q == NB_DBITS'(i)) begin
                shift_d[i] = rx_s;
              end
            end
            if (n_cnt_q == (len_q - NB_DBITS'(1))) begin
              stop_idx_d = 1'b0;
              state_d    = parity_enabled(par_mode_q) ? ST_PARITY : ST_STOP;
            end else begin
              n_cnt_d = n_cnt_q + NB_DBITS'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + NB_SCNT'(1);
          end
        end
      end

      ST_PARITY: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d    = '0;
            par_bit_d  = rx_s;
            stop_idx_d = 1'b0;
            state_d    = ST_STOP;
          end else begin
            s_cnt_d = s_cnt_q + NB_SCNT'(1);
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            if (two_stop_q && !stop_idx_q) begin
              // First of two stop bits: remember it and always take the second.
              stop_idx_d  = 1'b1;
              ferr_acc_d  = ferr_now;
              stop1_bad_d = stop1_bad_now;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              rdata_d = shift_q;
              ferr_d  = ferr_now;
              perr_d  = 1'b0;
              if (par_mode_q == PAR_EVEN) begin
                perr_d = data_par ^ par_bit_q;
              end else if (par_mode_q == PAR_ODD) begin
                perr_d = ~(data_par ^ par_bit_q);
              end
              brk_d = (shift_q == '0) &&
                      (!parity_enabled(par_mode_q) || !par_bit_q) &&
                      stop1_bad_now;
              // A held-low line must not produce back-to-back frames.
              if (ferr_now) begin
                armed_d = 1'b0;
              end
            end
          end else begin
            s_cnt_d = s_cnt_q + NB_SCNT'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      s_cnt_q     <= '0;
      n_cnt_q     <= '0;
      shift_q     <= '0;
      len_q       <= NB_DBITS'(NB_DATA);
      par_mode_q  <= PAR_NONE;
      two_stop_q  <= 1'b0;
      stop_idx_q  <= 1'b0;
      par_bit_q   <= 1'b0;
      ferr_acc_q  <= 1'b0;
      stop1_bad_q <= 1'b0;
      armed_q     <= 1'b1;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      n_cnt_q     <= n_cnt_d;
      shift_q     <= shift_d;
      len_q       <= len_d;
      par_mode_q  <= par_mode_d;
      two_stop_q  <= two_stop_d;
      stop_idx_q  <= stop_idx_d;
      par_bit_q   <= par_bit_d;
      ferr_acc_q  <= ferr_acc_d;
      stop1_bad_q <= stop1_bad_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      brk_q       <= brk_d;
    end
  end

  assign o_rdata      = rdata_q;
  assign o_rx_done    = done_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_break      = brk_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: serial frames built from hand-computed
// bit vectors (LSB = start bit, sent first), results checked at done.
module tb_uart_rx_cfg;

  localparam int NB_DATA    = 8;
  localparam int NB_COUNTER = 32;
  localparam int NB_DBITS   = 4;
  localparam int BITC       = 16;   // clocks per bit at i_tick_cmp = 1

  logic                  clk;
  logic                  i_rst_n;
  logic                  i_rx;
  logic                  i_en;
  logic [NB_COUNTER-1:0] i_tick_cmp;
  logic [NB_DBITS-1:0]   i_data_bits;
  logic [1:0]            i_parity_mode;
  logic                  i_two_stop;
  logic [NB_DATA-1:0]    o_rdata;
  logic                  o_rx_done;
  logic                  o_parity_err;
  logic                  o_frame_err;
  logic                  o_break;
  logic                  o_busy;

  int err_cnt  = 0;
  int chk_cnt  = 0;
  int done_cnt = 0;
  int done0;
  logic [NB_DATA-1:0] cap_rdata;
  logic               cap_perr, cap_ferr, cap_brk;

  uart_rx_cfg #(
    .NB_DATA    (NB_DATA),
    .NB_COUNTER (NB_COUNTER),
    .NB_SYNC    (2),
    .OVERSAMPLE (16),
    .NB_DBITS   (NB_DBITS)
  ) dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_rx          (i_rx),
    .i_en          (i_en),
    .i_tick_cmp    (i_tick_cmp),
    .i_data_bits   (i_data_bits),
    .i_parity_mode (i_parity_mode),
    .i_two_stop    (i_two_stop),
    .o_rdata       (o_rdata),
    .o_rx_done     (o_rx_done),
    .o_parity_err  (o_parity_err),
    .o_frame_err   (o_frame_err),
    .o_break       (o_break),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture results on every done pulse, away from the active edge.
  always @(negedge clk) begin
    if (o_rx_done) begin
      done_cnt  = done_cnt + 1;
      cap_rdata = o_rdata;
      cap_perr  = o_parity_err;
      cap_ferr  = o_frame_err;
      cap_brk   = o_break;
      $display("frame: done #%0d rdata=0x%02h perr=%0b ferr=%0b brk=%0b",
               done_cnt, o_rdata, o_parity_err, o_frame_err, o_break);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    if (obs !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n, input int bit_clks,
                            input logic end_lvl);
    for (int i = 0; i < n; i++) begin
      i_rx = bits[i];
      cycles(bit_clks);
    end
    i_rx = end_lvl;
  endtask

  task automatic set_cfg(input logic [3:0] dbits, input logic [1:0] pm, input logic two);
    i_data_bits   = dbits;
    i_parity_mode = pm;
    i_two_stop    = two;
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_rx       = 1'b1;
    i_en       = 1'b1;
    i_tick_cmp = 32'd1;
    set_cfg(4'd8, 2'b00, 1'b0);
    cycles(3);
    @(negedge clk);
    check("rst_rdata", o_rdata, 0);
    check("rst_done",  o_rx_done, 0);
    check("rst_perr",  o_parity_err, 0);
    check("rst_ferr",  o_frame_err, 0);
    check("rst_brk",   o_break, 0);
    check("rst_busy",  o_busy, 0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    cycles(2 * BITC);

    // 8N1 0x55
    done0 = done_cnt;
    send_frame((32'h1 << 9) | (32'h55 << 1), 10, BITC, 1'b1);
    cycles(2 * BITC);
    check("8n1_done",  done_cnt - done0, 1);
    check("8n1_rdata", cap_rdata, 32'h55);
    check("8n1_perr",  cap_perr, 0);
    check("8n1_ferr",  cap_ferr, 0);
    check("8n1_brk",   cap_brk, 0);
    check("8n1_busy",  o_busy, 0);

    // 7E2 0x41, correct parity bit 0
    set_cfg(4'd7, 2'b01, 1'b1);
    done0 = done_cnt;
    send_frame((32'h3 << 9) | (32'h0 << 8) | (32'h41 << 1), 11, BITC, 1'b1);
    cycles(2 * BITC);
    check("7e2_done",  done_cnt - done0, 1);
    check("7e2_rdata", cap_rdata, 32'h41);
    check("7e2_perr",  cap_perr, 0);
    check("7e2_ferr",  cap_ferr, 0);

    // 7E2 0x41, wrong parity bit 1
    done0 = done_cnt;
    send_frame((32'h3 << 9) | (32'h1 << 8) | (32'h41 << 1), 11, BITC, 1'b1);
    cycles(2 * BITC);
    check("7e2b_done",  done_cnt - done0, 1);
    check("7e2b_rdata", cap_rdata, 32'h41);
    check("7e2b_perr",  cap_perr, 1);

    // 5N1 0x1B: shortest length, right-justified
    set_cfg(4'd5, 2'b00, 1'b0);
    done0 = done_cnt;
    send_frame((32'h1 << 6) | (32'h1B << 1), 7, BITC, 1'b1);
    cycles(2 * BITC);
    check("5n1_done",  done_cnt - done0, 1);
    check("5n1_rdata", cap_rdata, 32'h1B);
    check("5n1_ferr",  cap_ferr, 0);

    // Length 3 is out of range and decodes as 8 bits: 0x96
    set_cfg(4'd3, 2'b00, 1'b0);
    done0 = done_cnt;
    send_frame((32'h1 << 9) | (32'h96 << 1), 10, BITC, 1'b1);
    cycles(2 * BITC);
    check("clamp_done",  done_cnt - done0, 1);
    check("clamp_rdata", cap_rdata, 32'h96);

    // 8O1 0xA3 (parity 1), stop bit 0, then line held low 40 bit times
    set_cfg(4'd8, 2'b10, 1'b0);
    done0 = done_cnt;
    send_frame((32'h0 << 10) | (32'h1 << 9) | (32'hA3 << 1), 11, BITC, 1'b0);
    cycles(40 * BITC);
    check("8o1_done",  done_cnt - done0, 1);
    check("8o1_rdata", cap_rdata, 32'hA3);
    check("8o1_perr",  cap_perr, 0);
    check("8o1_ferr",  cap_ferr, 1);
    check("8o1_brk",   cap_brk, 0);
    i_rx = 1'b1;
    cycles(2 * BITC);
    check("hold_nodone", done_cnt - done0, 1);
    send_frame((32'h3 << 9) | (32'h0F << 1), 11, BITC, 1'b1);
    cycles(2 * BITC);
    check("rearm_done",  done_cnt - done0, 2);
    check("rearm_rdata", cap_rdata, 32'h0F);
    check("rearm_ferr",  cap_ferr, 0);
    check("rearm_perr",  cap_perr, 0);

    // Start glitch: 4 clocks low
    set_cfg(4'd8, 2'b00, 1'b0);
    done0 = done_cnt;
    i_rx = 1'b0;
    cycles(4);
    i_rx = 1'b1;
    check("glitch_busy_hi", o_busy, 1);
    cycles(20);
    check("glitch_busy_lo", o_busy, 0);
    check("glitch_nodone",  done_cnt - done0, 0);

    // Length changed 8 -> 5 mid-frame: still 8 bits, 0xB5
    done0 = done_cnt;
    fork
      send_frame((32'h1 << 9) | (32'hB5 << 1), 10, BITC, 1'b1);
      begin
        cycles(40);
        i_data_bits = 4'd5;
      end
    join
    cycles(2 * BITC);
    check("midcfg_done",  done_cnt - done0, 1);
    check("midcfg_rdata", cap_rdata, 32'hB5);
    check("midcfg_ferr",  cap_ferr, 0);
    i_data_bits = 4'd8;

    // Break: low for 12 bit times, 8N1
    done0 = done_cnt;
    send_frame(32'h0, 12, BITC, 1'b1);
    cycles(3 * BITC);
    check("brk_done",  done_cnt - done0, 1);
    check("brk_rdata", cap_rdata, 0);
    check("brk_ferr",  cap_ferr, 1);
    check("brk_brk",   cap_brk, 1);

    // 0xC3 at divisor 27, reset during DATA, then 0x3C
    i_tick_cmp = 32'd27;
    done0 = done_cnt;
    send_frame(32'hC3 << 1, 4, 16 * 27, 1'b0);
    check("pre_rst_busy", o_busy, 1);
    i_rst_n = 1'b0;
    i_rx    = 1'b1;
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_ferr", o_frame_err, 0);
    check("mid_rst_brk",  o_break, 0);
    check("mid_rst_done", o_rx_done, 0);
    check("mid_rst_rdata", o_rdata, 0);
    cycles(5);
    i_rst_n = 1'b1;
    cycles(2 * 16 * 27);
    check("rst_nodone", done_cnt - done0, 0);
    send_frame((32'h1 << 9) | (32'h3C << 1), 10, 16 * 27, 1'b1);
    cycles(2 * 16 * 27);
    check("post_rst_done",  done_cnt - done0, 1);
    check("post_rst_rdata", cap_rdata, 32'h3C);
    check("post_rst_ferr",  cap_ferr, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
